// File: rtl/burst_scheduler.sv
// burst_scheduler: picks the next full burst slot (aged > row hit > same direction > any, round-robin ties).
// Define BURST_SCHED_AGING_EN to add per-slot age counters and the aged priority class.
module burst_scheduler #(
  parameter int NO_OF_BURSTS = 4,
  parameter int BANK_W       = 2,
  parameter int BG_W         = 2,
  parameter int ROW_W        = 16,
  parameter int AGE_MAX      = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NO_OF_BURSTS-1:0]           slot_full,
  input  logic [NO_OF_BURSTS-1:0]           slot_write,
  input  logic [NO_OF_BURSTS*BANK_W-1:0]    slot_bank,
  input  logic [NO_OF_BURSTS*BG_W-1:0]      slot_bg,
  input  logic [NO_OF_BURSTS*ROW_W-1:0]     slot_row,
  output logic                              sel_valid,
  output logic [$clog2(NO_OF_BURSTS)-1:0]   sel_idx,
  output logic                              sel_write,
  input  logic                              sel_ready,
  input  logic                              sel_done,
  output logic                              busy
);

  localparam int IDX_W = $clog2(NO_OF_BURSTS);

  if (NO_OF_BURSTS < 2 || NO_OF_BURSTS > 16 || AGE_MAX < 1) begin : g_bad_cfg
    $error("burst_scheduler: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         ptr, pick_idx;
  logic                     last_write;
  logic [BANK_W-1:0]        last_bank;
  logic [BG_W-1:0]          last_bg;
  logic [ROW_W-1:0]         last_row;
  logic [NO_OF_BURSTS-1:0]  hit_m, dir_m, class_m;
  logic [IDX_W:0]           cand;
  logic                     found;
  logic                     transfer;

  assign transfer = (state == OFFER) && sel_ready;

`ifdef BURST_SCHED_AGING_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);

  logic [AGE_W-1:0]        age [NO_OF_BURSTS];
  logic [NO_OF_BURSTS-1:0] aged_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NO_OF_BURSTS; k++) age[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NO_OF_BURSTS; k++) begin
        if (!slot_full[k]) age[k] <= '0;
        else if (transfer) begin
          if (IDX_W'(k) == sel_idx) age[k] <= '0;
          else if (age[k] != AGE_W'(AGE_MAX)) age[k] <= age[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    aged_m = '0;
    for (int unsigned k = 0; k < NO_OF_BURSTS; k++)
      aged_m[k] = slot_full[k] && (age[k] == AGE_W'(AGE_MAX));
  end
`endif

  always_comb begin
    hit_m = '0;
    dir_m = '0;
    for (int unsigned k = 0; k < NO_OF_BURSTS; k++) begin
      hit_m[k] = slot_full[k]
              && (slot_bank[k*BANK_W +: BANK_W] == last_bank)
              && (slot_bg[k*BG_W +: BG_W] == last_bg)
              && (slot_row[k*ROW_W +: ROW_W] == last_row);
      dir_m[k] = slot_full[k] && (slot_write[k] == last_write);
    end
    if (|hit_m)      class_m = hit_m;
    else if (|dir_m) class_m = dir_m;
    else             class_m = slot_full;
`ifdef BURST_SCHED_AGING_EN
    if (|aged_m)     class_m = aged_m;
`endif
  end

  // Rotating scan: first candidate at or after ptr, wrapping past N-1.
  always_comb begin
    pick_idx = ptr;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NO_OF_BURSTS; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NO_OF_BURSTS)) cand = cand - (IDX_W+1)'(NO_OF_BURSTS);
      if (!found && class_m[cand[IDX_W-1:0]]) begin
        pick_idx = cand[IDX_W-1:0];
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:  if (|slot_full) state_nxt = OFFER;
      OFFER: begin
        sel_valid = 1'b1;
        if (sel_ready)               state_nxt = BUSY;
        else if (!slot_full[sel_idx]) state_nxt = IDLE;
      end
      BUSY: begin
        busy = 1'b1;
        if (sel_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_idx    <= '0;
      sel_write  <= 1'b0;
      last_write <= 1'b0;
      last_bank  <= '0;
      last_bg    <= '0;
      last_row   <= '0;
      ptr        <= '0;
    end else begin
      if (state == IDLE && |slot_full) begin
        sel_idx   <= pick_idx;
        sel_write <= slot_write[pick_idx];
      end
      if (transfer) begin
        last_write <= sel_write;
        last_bank  <= slot_bank[sel_idx*BANK_W +: BANK_W];
        last_bg    <= slot_bg[sel_idx*BG_W +: BG_W];
        last_row   <= slot_row[sel_idx*ROW_W +: ROW_W];
        ptr        <= (sel_idx == IDX_W'(NO_OF_BURSTS-1)) ? '0 : sel_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_burst_scheduler.sv
// Directed bench for burst_scheduler with a rank-based reference model checked every cycle.
// Aging expectations follow BURST_SCHED_AGING_EN.
module tb_burst_scheduler;
  localparam int N       = 4;
  localparam int BANK_W  = 2;
  localparam int BG_W    = 2;
  localparam int ROW_W   = 16;
  localparam int AGE_MAX = 15;
  localparam int IDX_W   = $clog2(N);

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          slot_full = '0;
  logic [N-1:0]          slot_write = '0;
  logic [N*BANK_W-1:0]   slot_bank = '0;
  logic [N*BG_W-1:0]     slot_bg = '0;
  logic [N*ROW_W-1:0]    slot_row = '0;
  logic                  sel_valid;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_write;
  logic                  sel_ready = 1'b0;
  logic                  sel_done = 1'b0;
  logic                  busy;

  int n_vec = 0;
  int n_bad = 0;
  int rows[N];

  burst_scheduler #(
    .NO_OF_BURSTS(N), .BANK_W(BANK_W), .BG_W(BG_W), .ROW_W(ROW_W), .AGE_MAX(AGE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slot_full(slot_full), .slot_write(slot_write),
    .slot_bank(slot_bank), .slot_bg(slot_bg), .slot_row(slot_row),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .sel_write(sel_write),
    .sel_ready(sel_ready), .sel_done(sel_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: offer pending / in service flags plus a rank = class*N + rotational distance.
  bit m_valid = 0, m_busy = 0, m_write = 0, m_last_write = 0;
  int m_idx = 0, m_ptr = 0, m_last_bank = 0, m_last_bg = 0, m_last_row = 0;
  int m_age[N];

  function automatic int model_pick();
    int best = 0;
    int best_key = 1 << 30;
    for (int i = 0; i < N; i++) begin
      int cls;
      int key;
      if (!slot_full[i]) continue;
      cls = 3;
      if (slot_write[i] == m_last_write) cls = 2;
      if (int'(slot_bank[i*BANK_W +: BANK_W]) == m_last_bank &&
          int'(slot_bg[i*BG_W +: BG_W]) == m_last_bg &&
          int'(slot_row[i*ROW_W +: ROW_W]) == m_last_row) cls = 1;
`ifdef BURST_SCHED_AGING_EN
      if (m_age[i] == AGE_MAX) cls = 0;
`endif
      key = cls * N + (i - m_ptr + N) % N;
      if (key < best_key) begin
        best_key = key;
        best = i;
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_busy = 0; m_write = 0; m_idx = 0; m_ptr = 0;
      m_last_write = 0; m_last_bank = 0; m_last_bg = 0; m_last_row = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else begin
      if (m_busy) begin
        if (sel_done) m_busy = 0;
      end else if (m_valid) begin
        if (sel_ready) begin
          for (int i = 0; i < N; i++)
            if (i == m_idx) m_age[i] = 0;
            else if (slot_full[i] && m_age[i] < AGE_MAX) m_age[i]++;
          m_last_write = m_write;
          m_last_bank  = int'(slot_bank[m_idx*BANK_W +: BANK_W]);
          m_last_bg    = int'(slot_bg[m_idx*BG_W +: BG_W]);
          m_last_row   = int'(slot_row[m_idx*ROW_W +: ROW_W]);
          m_ptr   = (m_idx + 1) % N;
          m_valid = 0;
          m_busy  = 1;
        end else if (!slot_full[m_idx]) begin
          m_valid = 0;
        end
      end else if (slot_full != '0) begin
        m_idx   = model_pick();
        m_write = slot_write[m_idx];
        m_valid = 1;
      end
      for (int i = 0; i < N; i++) if (!slot_full[i]) m_age[i] = 0;
    end
  end

  always @(negedge clk) begin
    check("sel_valid", sel_valid, m_valid);
    check("busy", busy, m_busy);
    if (m_valid) begin
      check("sel_idx", sel_idx, m_idx);
      check("sel_write", sel_write, m_write);
    end
  end

  task automatic set_slot(int i, bit f, bit w, int b, int g, int r);
    slot_full[i]               = f;
    slot_write[i]              = w;
    slot_bank[i*BANK_W +: BANK_W] = BANK_W'(b);
    slot_bg[i*BG_W +: BG_W]       = BG_W'(g);
    slot_row[i*ROW_W +: ROW_W]    = ROW_W'(r);
  endtask

  task automatic clear_slots();
    slot_full = '0; slot_write = '0; slot_bank = '0; slot_bg = '0; slot_row = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    clear_slots();
    sel_ready = 1'b0;
    sel_done  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic serve(output int idx);
    int t = 0;
    idx = -1;
    while (sel_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sel_valid !== 1'b1) begin
      check("offer_timeout", sel_valid, 1);
      return;
    end
    idx = int'(sel_idx);
    sel_ready = 1'b1;
    @(negedge clk);
    sel_ready = 1'b0;
    check("busy_after_accept", busy, 1);
    check("valid_after_accept", sel_valid, 0);
    sel_done = 1'b1;
    @(negedge clk);
    sel_done = 1'b0;
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    for (int i = 0; i < N; i++) set_slot(i, 1, 0, 0, 0, 0);

    // Reset held with every slot full
    repeat (3) @(negedge clk);
    check("rst_valid", sel_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", sel_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", sel_valid, 1);
    check("post_rst_idx", sel_idx, 0);
    serve(idx);
    clear_slots();

    // Stray ready/done while idle must be ignored
    sel_ready = 1'b1; sel_done = 1'b1;
    @(negedge clk);
    sel_ready = 1'b0; sel_done = 1'b0;
    check("stray_busy", busy, 0);

    // Single read in slot 2
    set_slot(2, 1, 0, 1, 1, 33);
    @(negedge clk);
    check("single_valid", sel_valid, 1);
    check("single_idx", sel_idx, 2);
    check("single_write", sel_write, 0);
    serve(idx);
    clear_slots();

    // Direction grouping after reset (last = read)
    do_reset();
    set_slot(1, 1, 1, 1, 0, 10);
    set_slot(3, 1, 0, 2, 0, 11);
    @(negedge clk);
    check("dir_idx", sel_idx, 3);
    serve(idx);
    clear_slots();

    // Row hit beats round-robin
    do_reset();
    set_slot(3, 1, 0, 0, 0, 5);
    serve(idx);
    check("rowhit_seed", idx, 3);
    clear_slots();
    set_slot(0, 1, 1, 0, 0, 7);
    set_slot(2, 1, 1, 0, 0, 5);
    @(negedge clk);
    check("rowhit_idx", sel_idx, 2);
    serve(idx);
    clear_slots();

    // Offer frozen while pending, then withdrawn
    do_reset();
    set_slot(1, 1, 0, 1, 0, 20);
    @(negedge clk);
    check("frozen_first", sel_idx, 1);
    set_slot(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("frozen_idx", sel_idx, 1);
    check("frozen_valid", sel_valid, 1);
    slot_full[1] = 1'b0;
    @(negedge clk);
    check("withdraw_valid", sel_valid, 0);
    @(negedge clk);
    check("reoffer_valid", sel_valid, 1);
    check("reoffer_idx", sel_idx, 0);
    serve(idx);
    clear_slots();

    // Round robin among writes with no row hits
    do_reset();
    set_slot(1, 1, 1, 1, 0, 100);
    serve(idx);
    check("rr_seed", idx, 1);
    clear_slots();
    for (int i = 0; i < N; i++) begin
      rows[i] = 200 + i;
      set_slot(i, 1, 1, i, 1, rows[i]);
    end
    for (int k = 0; k < 3; k++) begin
      int exp_rr[3] = '{2, 3, 0};
      serve(idx);
      check("rr_idx", idx, exp_rr[k]);
      if (idx >= 0) begin
        rows[idx] += 16;
        set_slot(idx, 1, 1, idx, 1, rows[idx]);
      end
    end

    // Asynchronous reset while a burst is in service
    @(negedge clk);
    sel_ready = 1'b1;
    @(negedge clk);
    sel_ready = 1'b0;
    check("midrst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", sel_valid, 0);
    check("midrst_idx", sel_idx, 0);
    clear_slots();
    @(negedge clk);
    rst_n = 1'b1;

    // Aging: write in slot 0 competes with continually refilled reads
    do_reset();
    set_slot(0, 1, 1, 3, 3, 900);
    for (int i = 1; i < N; i++) begin
      rows[i] = 300 + i;
      set_slot(i, 1, 0, i, 0, rows[i]);
    end
    for (int g = 0; g < 16; g++) begin
      serve(idx);
`ifdef BURST_SCHED_AGING_EN
      if (g == 15) check("aged_wins", idx, 0);
      else         check("aged_not_yet", idx != 0, 1);
`else
      check("no_aging_starves", idx != 0, 1);
`endif
      if (idx > 0) begin
        rows[idx] += 16;
        set_slot(idx, 1, 0, idx, 0, rows[idx]);
      end
    end
    clear_slots();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
